// File: rtl/seq_mem_d1_2p_if.sv
// Port bundle for seq_mem_d1_2p: an independent read port, an independent
// write port, and the shared status flag.
interface seq_mem_d1_2p_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] raddr;
  logic                read_en;
  logic [WIDTH-1:0]    out;
  logic                read_done;
  logic [IDX_SIZE-1:0] waddr;
  logic [WIDTH-1:0]    in;
  logic [WIDTH/8-1:0]  write_mask;
  logic                write_en;
  logic                write_done;
  logic                error;

  modport master (
    output raddr, read_en, waddr, in, write_mask, write_en,
    input  out, read_done, write_done, error
  );

  modport slave (
    input  raddr, read_en, waddr, in, write_mask, write_en,
    output out, read_done, write_done, error
  );
endinterface

// File: rtl/seq_mem_d1_2p.sv
// Simple dual-port memory with byte-masked writes, a 1..4 cycle read pipeline
// and selectable same-address read-during-write behaviour.
module seq_mem_d1_2p #(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 16,
  parameter int IDX_SIZE     = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic           clk,
  input  logic           reset,
  seq_mem_d1_2p_if.slave bus
);
  localparam int                BYTES    = WIDTH / 8;
  localparam logic [IDX_SIZE:0] SIZE_LIM = (IDX_SIZE + 1)'(SIZE);

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("seq_mem_d1_2p: WIDTH must be a positive multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("seq_mem_d1_2p: READ_LATENCY must be in 1..4");
    end
    if (SIZE < 1 || SIZE > (2 ** IDX_SIZE)) begin : g_bad_size
      $error("seq_mem_d1_2p: SIZE must be in 1..2**IDX_SIZE");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
      $error("seq_mem_d1_2p: RDW_MODE must be 0 or 1");
    end
  endgenerate

  logic rd_in_bounds;
  logic wr_in_bounds;
  logic rd_fire;
  logic wr_fire;
  logic fwd_hit;

  assign rd_in_bounds = {1'b0, bus.raddr} < SIZE_LIM;
  assign wr_in_bounds = {1'b0, bus.waddr} < SIZE_LIM;
  assign rd_fire      = bus.read_en && rd_in_bounds;
  assign wr_fire      = bus.write_en && wr_in_bounds;
  assign fwd_hit      = (RDW_MODE == 1) && rd_fire && wr_fire && (bus.raddr == bus.waddr);

  // Storage: registered read, byte-enabled write, no reset so it maps onto block RAM.
  // Nonblocking update means a same-edge read naturally sees the old word.
  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] ram_rd_reg;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.write_mask[b]) begin
          mem[bus.waddr][b*8 +: 8] <= bus.in[b*8 +: 8];
        end
      end
    end
    if (rd_fire) begin
      ram_rd_reg <= mem[bus.raddr];
    end
  end

  // Side-band captured alongside the RAM read: out-of-bounds squash and the
  // colliding write, merged after the RAM register instead of in front of it.
  logic              oob_reg;
  logic              fwd_reg;
  logic [WIDTH-1:0]  fwd_data_reg;
  logic [BYTES-1:0]  fwd_mask_reg;

  always_ff @(posedge clk) begin
    if (bus.read_en) begin
      oob_reg      <= !rd_in_bounds;
      fwd_reg      <= fwd_hit;
      fwd_data_reg <= bus.in;
      fwd_mask_reg <= bus.write_mask;
    end
  end

  logic [WIDTH-1:0] s0_data;

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
      assign s0_data[gi*8 +: 8] = oob_reg                          ? 8'h00 :
                                  (fwd_reg && fwd_mask_reg[gi])    ? fwd_data_reg[gi*8 +: 8] :
                                                                     ram_rd_reg[gi*8 +: 8];
    end
  endgenerate

  // Bit k marks a read sampled k edges ago; only these are cleared by reset.
  logic [READ_LATENCY-1:0] pipe_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= bus.read_en;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
      end
    end
  end

  logic [WIDTH-1:0] tail_data;

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign tail_data = s0_data;
    end else begin : g_stages
      logic [WIDTH-1:0] stage_data_reg [1:READ_LATENCY-1];

      always_ff @(posedge clk) begin
        if (pipe_valid_reg[0]) begin
          stage_data_reg[1] <= s0_data;
        end
        for (int k = 2; k < READ_LATENCY; k++) begin
          if (pipe_valid_reg[k-1]) begin
            stage_data_reg[k] <= stage_data_reg[k-1];
          end
        end
      end

      assign tail_data = stage_data_reg[READ_LATENCY-1];
    end
  endgenerate

  logic [WIDTH-1:0] out_reg;
  logic             read_done_reg;
  logic             write_done_reg;
  logic             error_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg        <= '0;
      read_done_reg  <= 1'b0;
      write_done_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      read_done_reg  <= pipe_valid_reg[READ_LATENCY-1];
      write_done_reg <= bus.write_en;
      if (pipe_valid_reg[READ_LATENCY-1]) begin
        out_reg <= tail_data;
      end
      if ((bus.read_en && !rd_in_bounds) || (bus.write_en && !wr_in_bounds)) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign bus.out        = out_reg;
  assign bus.read_done  = read_done_reg;
  assign bus.write_done = write_done_reg;
  assign bus.error      = error_reg;
endmodule

// File: tb/tb_seq_mem_d1_2p.sv
// Drives three differently configured seq_mem_d1_2p instances with identical
// traffic and checks each against a per-instance behavioural scoreboard.
module tb_seq_mem_d1_2p;
  localparam int ND   = 3;
  localparam int SZ0  = 12;
  localparam int LAT0 = 1;
  localparam int RDW0 = 0;
  localparam int SZ1  = 16;
  localparam int LAT1 = 3;
  localparam int RDW1 = 1;
  localparam int SZ2  = 16;
  localparam int LAT2 = 4;
  localparam int RDW2 = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  raddr = '0;
  logic [3:0]  waddr = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;

  always #5 clk = ~clk;

  seq_mem_d1_2p_if #(.WIDTH(32), .IDX_SIZE(4)) ifc0 ();
  seq_mem_d1_2p_if #(.WIDTH(32), .IDX_SIZE(4)) ifc1 ();
  seq_mem_d1_2p_if #(.WIDTH(32), .IDX_SIZE(4)) ifc2 ();

  assign ifc0.raddr = raddr;  assign ifc0.read_en = read_en;  assign ifc0.waddr = waddr;
  assign ifc0.in = wdata;     assign ifc0.write_mask = wmask; assign ifc0.write_en = write_en;
  assign ifc1.raddr = raddr;  assign ifc1.read_en = read_en;  assign ifc1.waddr = waddr;
  assign ifc1.in = wdata;     assign ifc1.write_mask = wmask; assign ifc1.write_en = write_en;
  assign ifc2.raddr = raddr;  assign ifc2.read_en = read_en;  assign ifc2.waddr = waddr;
  assign ifc2.in = wdata;     assign ifc2.write_mask = wmask; assign ifc2.write_en = write_en;

  seq_mem_d1_2p #(.WIDTH(32), .SIZE(SZ0), .IDX_SIZE(4), .READ_LATENCY(LAT0), .RDW_MODE(RDW0))
    dut0 (.clk(clk), .reset(reset), .bus(ifc0.slave));
  seq_mem_d1_2p #(.WIDTH(32), .SIZE(SZ1), .IDX_SIZE(4), .READ_LATENCY(LAT1), .RDW_MODE(RDW1))
    dut1 (.clk(clk), .reset(reset), .bus(ifc1.slave));
  seq_mem_d1_2p #(.WIDTH(32), .SIZE(SZ2), .IDX_SIZE(4), .READ_LATENCY(LAT2), .RDW_MODE(RDW2))
    dut2 (.clk(clk), .reset(reset), .bus(ifc2.slave));

  logic [31:0] dut_out   [ND];
  logic        dut_rdone [ND];
  logic        dut_wdone [ND];
  logic        dut_err   [ND];

  assign dut_out[0] = ifc0.out;  assign dut_rdone[0] = ifc0.read_done;
  assign dut_wdone[0] = ifc0.write_done;  assign dut_err[0] = ifc0.error;
  assign dut_out[1] = ifc1.out;  assign dut_rdone[1] = ifc1.read_done;
  assign dut_wdone[1] = ifc1.write_done;  assign dut_err[1] = ifc1.error;
  assign dut_out[2] = ifc2.out;  assign dut_rdone[2] = ifc2.read_done;
  assign dut_wdone[2] = ifc2.write_done;  assign dut_err[2] = ifc2.error;

  // Reference model: word array plus reads scheduled by delivery edge.
  int          cfg_size [ND];
  int          cfg_lat  [ND];
  int          cfg_rdw  [ND];
  logic [31:0] mmem     [ND][16];
  bit          due_v    [ND][8];
  logic [31:0] due_d    [ND][8];
  logic [31:0] exp_out  [ND];
  logic        exp_rdone[ND];
  logic        exp_wdone[ND];
  logic        exp_err  [ND];
  int          edge_n = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic cycle(input logic re, input logic [3:0] ra, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] wm);
    read_en = re; raddr = ra; write_en = we; waddr = wa; wdata = wd; wmask = wm;
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < ND; d++) begin
      int          slot;
      logic [31:0] rv;
      slot = edge_n % 8;
      exp_rdone[d] = due_v[d][slot];
      if (due_v[d][slot]) exp_out[d] = due_d[d][slot];
      due_v[d][slot] = 1'b0;
      if (re) begin
        if (int'(ra) >= cfg_size[d]) begin
          rv = 32'h0;
          exp_err[d] = 1'b1;
        end else begin
          rv = mmem[d][ra];
          if (cfg_rdw[d] == 1 && we && wa == ra) rv = merge(rv, wd, wm);
        end
        due_v[d][(edge_n + cfg_lat[d]) % 8] = 1'b1;
        due_d[d][(edge_n + cfg_lat[d]) % 8] = rv;
      end
      exp_wdone[d] = we;
      if (we) begin
        if (int'(wa) >= cfg_size[d]) exp_err[d] = 1'b1;
        else mmem[d][wa] = merge(mmem[d][wa], wd, wm);
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic assert_reset();
    read_en = 1'b0; write_en = 1'b0;
    reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      for (int s = 0; s < 8; s++) due_v[d][s] = 1'b0;
      exp_out[d] = 32'h0; exp_rdone[d] = 1'b0; exp_wdone[d] = 1'b0; exp_err[d] = 1'b0;
    end
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    assert_reset();
    for (int d = 0; d < ND; d++) begin
      checks += 4;
      if (dut_out[d] !== 32'h0) begin failures++; $display("FAIL reset_out dut%0d: got %h expected 0", d, dut_out[d]); end
      if (dut_rdone[d] !== 1'b0) begin failures++; $display("FAIL reset_read_done dut%0d: got %b expected 0", d, dut_rdone[d]); end
      if (dut_wdone[d] !== 1'b0) begin failures++; $display("FAIL reset_write_done dut%0d: got %b expected 0", d, dut_wdone[d]); end
      if (dut_err[d] !== 1'b0) begin failures++; $display("FAIL reset_error dut%0d: got %b expected 0", d, dut_err[d]); end
    end
    release_reset();
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'd0, 1'b1, 4'(a), $urandom, 4'hF);
      for (int d = 0; d < ND; d++) begin
        checks += 2;
        if (dut_wdone[d] !== 1'b1) begin failures++; $display("FAIL fill_write_done dut%0d addr%0d: got %b expected 1", d, a, dut_wdone[d]); end
        if (dut_err[d] !== exp_err[d]) begin failures++; $display("FAIL fill_error dut%0d addr%0d: got %b expected %b", d, a, dut_err[d], exp_err[d]); end
      end
    end
    idle();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (dut_wdone[d] !== 1'b0) begin failures++; $display("FAIL idle_write_done dut%0d: got %b expected 0", d, dut_wdone[d]); end
    end
  endtask

  task automatic test_basic();
    cycle(1'b0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    cycle(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (dut_rdone[d] !== (k == cfg_lat[d])) begin failures++; $display("FAIL basic_read_done dut%0d k%0d: got %b expected %b", d, k, dut_rdone[d], k == cfg_lat[d]); end
        if (k == cfg_lat[d]) begin
          checks++;
          if (dut_out[d] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_out dut%0d: got %h expected deadbeef", d, dut_out[d]); end
        end
      end
    end
    cycle(1'b0, 4'd0, 1'b1, 4'd5, 32'h11223344, 4'hF);
    cycle(1'b0, 4'd0, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
    cycle(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        if (k == cfg_lat[d]) begin
          checks += 2;
          if (dut_rdone[d] !== 1'b1) begin failures++; $display("FAIL mask_read_done dut%0d: got %b expected 1", d, dut_rdone[d]); end
          if (dut_out[d] !== 32'h11BB33DD) begin failures++; $display("FAIL mask_out dut%0d: got %h expected 11bb33dd", d, dut_out[d]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 10; j++) begin
      if (j < 4) cycle(1'b1, 4'(j), 1'b0, 4'd0, 32'd0, 4'd0);
      else idle();
      for (int d = 0; d < ND; d++) begin
        int idx;
        bit want;
        idx  = j - cfg_lat[d];
        want = (idx >= 0 && idx < 4);
        checks++;
        if (dut_rdone[d] !== want) begin failures++; $display("FAIL b2b_read_done dut%0d j%0d: got %b expected %b", d, j, dut_rdone[d], want); end
        if (want) begin
          checks++;
          if (dut_out[d] !== mmem[d][idx]) begin failures++; $display("FAIL b2b_out dut%0d j%0d: got %h expected %h", d, j, dut_out[d], mmem[d][idx]); end
        end
      end
    end
  endtask

  task automatic test_rdw();
    cycle(1'b0, 4'd0, 1'b1, 4'd7, 32'h1, 4'hF);
    cycle(1'b1, 4'd7, 1'b1, 4'd7, 32'h2, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) cycle(1'b0, 4'd0, 1'b1, 4'd7, 32'hFFFFFFFF, 4'h0);
      else idle();
      for (int d = 0; d < ND; d++) begin
        if (k == 1) begin
          checks++;
          if (dut_wdone[d] !== 1'b1) begin failures++; $display("FAIL mask0_write_done dut%0d: got %b expected 1", d, dut_wdone[d]); end
        end
        if (k == cfg_lat[d]) begin
          checks++;
          if (dut_out[d] !== ((cfg_rdw[d] == 1) ? 32'h2 : 32'h1)) begin failures++; $display("FAIL rdw_out dut%0d: got %h expected %h", d, dut_out[d], (cfg_rdw[d] == 1) ? 32'h2 : 32'h1); end
        end
      end
    end
    cycle(1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        if (k == cfg_lat[d]) begin
          checks++;
          if (dut_out[d] !== 32'h2) begin failures++; $display("FAIL rdw_mem dut%0d: got %h expected 2", d, dut_out[d]); end
        end
      end
    end
  endtask

  task automatic test_oob();
    assert_reset();
    release_reset();
    cycle(1'b1, 4'd13, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (dut_err[d] !== (d == 0)) begin failures++; $display("FAIL oob_rd_error dut%0d k%0d: got %b expected %b", d, k, dut_err[d], d == 0); end
        if (k == cfg_lat[d]) begin
          checks += 2;
          if (dut_rdone[d] !== 1'b1) begin failures++; $display("FAIL oob_read_done dut%0d: got %b expected 1", d, dut_rdone[d]); end
          if (dut_out[d] !== ((d == 0) ? 32'h0 : mmem[d][13])) begin failures++; $display("FAIL oob_out dut%0d: got %h", d, dut_out[d]); end
        end
      end
    end
    cycle(1'b0, 4'd0, 1'b1, 4'd12, 32'h5A5A5A5A, 4'hF);
    for (int d = 0; d < ND; d++) begin
      checks += 2;
      if (dut_wdone[d] !== 1'b1) begin failures++; $display("FAIL oob_write_done dut%0d: got %b expected 1", d, dut_wdone[d]); end
      if (dut_err[d] !== (d == 0)) begin failures++; $display("FAIL oob_wr_error dut%0d: got %b expected %b", d, dut_err[d], d == 0); end
    end
    cycle(1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        if (k == cfg_lat[d]) begin
          checks++;
          if (dut_out[d] !== ((d == 0) ? 32'h0 : 32'h5A5A5A5A)) begin failures++; $display("FAIL oob_readback dut%0d: got %h", d, dut_out[d]); end
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1'b1, 4'd9, 1'b0, 4'd0, 32'd0, 4'd0);
    idle();
    idle();
    assert_reset();
    for (int d = 0; d < ND; d++) begin
      checks += 3;
      if (dut_out[d] !== 32'h0) begin failures++; $display("FAIL inflight_out dut%0d: got %h expected 0", d, dut_out[d]); end
      if (dut_rdone[d] !== 1'b0) begin failures++; $display("FAIL inflight_read_done dut%0d: got %b expected 0", d, dut_rdone[d]); end
      if (dut_err[d] !== 1'b0) begin failures++; $display("FAIL inflight_error dut%0d: got %b expected 0", d, dut_err[d]); end
    end
    release_reset();
    for (int k = 0; k < 6; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (dut_rdone[d] !== 1'b0) begin failures++; $display("FAIL inflight_ghost dut%0d k%0d: got %b expected 0", d, k, dut_rdone[d]); end
      end
    end
    cycle(1'b1, 4'd9, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        if (k == cfg_lat[d]) begin
          checks += 2;
          if (dut_rdone[d] !== 1'b1) begin failures++; $display("FAIL postreset_read_done dut%0d: got %b expected 1", d, dut_rdone[d]); end
          if (dut_out[d] !== mmem[d][9]) begin failures++; $display("FAIL postreset_out dut%0d: got %h expected %h", d, dut_out[d], mmem[d][9]); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic re, we;
      logic [3:0] ra, wa, wm;
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      wm = 4'($urandom_range(0, 15));
      cycle(re, ra, we, wa, $urandom, wm);
      for (int d = 0; d < ND; d++) begin
        checks += 4;
        if (dut_rdone[d] !== exp_rdone[d]) begin failures++; $display("FAIL rand_read_done dut%0d c%0d: got %b expected %b", d, c, dut_rdone[d], exp_rdone[d]); end
        if (dut_out[d] !== exp_out[d]) begin failures++; $display("FAIL rand_out dut%0d c%0d: got %h expected %h", d, c, dut_out[d], exp_out[d]); end
        if (dut_wdone[d] !== exp_wdone[d]) begin failures++; $display("FAIL rand_write_done dut%0d c%0d: got %b expected %b", d, c, dut_wdone[d], exp_wdone[d]); end
        if (dut_err[d] !== exp_err[d]) begin failures++; $display("FAIL rand_error dut%0d c%0d: got %b expected %b", d, c, dut_err[d], exp_err[d]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cfg_size[0] = SZ0; cfg_lat[0] = LAT0; cfg_rdw[0] = RDW0;
    cfg_size[1] = SZ1; cfg_lat[1] = LAT1; cfg_rdw[1] = RDW1;
    cfg_size[2] = SZ2; cfg_lat[2] = LAT2; cfg_rdw[2] = RDW2;
    test_reset();
    test_fill();
    test_basic();
    test_back_to_back();
    test_rdw();
    test_oob();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
